// File: rtl/line_buffer_ctrl_if.sv
// Stream handshake and datapath-control bundle around line_buffer_ctrl.
// master = the controller; slave = the datapath/upstream/downstream side.
interface line_buffer_ctrl_if #(
  parameter int BW = 1
);
  logic          i_valid;
  logic          i_ready;
  logic          shift;
  logic          is_padding;
  logic [BW-1:0] out_blank;
  logic          o_valid;
  logic          o_ready;
  logic          o_last;

  modport master (
    input  i_valid, o_ready,
    output i_ready, shift, is_padding, out_blank, o_valid, o_last
  );

  modport slave (
    output i_valid, o_ready,
    input  i_ready, shift, is_padding, out_blank, o_valid, o_last
  );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Walks one zero-padded frame for line_buffer_datapath: shift/pad/blank control,
// input valid/ready acceptance and window-valid output with backpressure.
module line_buffer_ctrl #(
  parameter int IN_HEIGHT  = 512,
  parameter int IN_WIDTH   = 512,
  parameter int KERNEL_0   = 3,
  parameter int KERNEL_1   = 3,
  parameter int DILATION_0 = 2,
  parameter int DILATION_1 = 2,
  parameter int PADDING_0  = 2,
  parameter int PADDING_1  = 2,
  parameter int STRIDE_0   = 1,
  parameter int STRIDE_1   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               frame_done,
  line_buffer_ctrl_if.master bus
);
  localparam int TW        = IN_WIDTH + 2*PADDING_1;
  localparam int TH        = IN_HEIGHT + 2*PADDING_0;
  localparam int W0        = DILATION_0*(KERNEL_0-1) + 1;
  localparam int W1        = DILATION_1*(KERNEL_1-1) + 1;
  localparam int BLANK_LIM = PADDING_0*TW + PADDING_1;

  // Linear distance from the newest window point back to kernel point p.
  function automatic int kofs(input int p);
    return (KERNEL_0-1-p/KERNEL_1)*DILATION_0*TW + (KERNEL_1-1-p%KERNEL_1)*DILATION_1;
  endfunction

  function automatic int count_blank();
    int n;
    n = 0;
    for (int p = 0; p < KERNEL_0*KERNEL_1; p++)
      if (kofs(p) > (W0-1)*TW + (W1-1) - BLANK_LIM) n++;
    return n;
  endfunction

  localparam int BLANK_PTS      = count_blank();
  localparam int BLANK_PTS_SAFE = (BLANK_PTS > 0) ? BLANK_PTS : 1;
  localparam int RW     = $clog2(TH);
  localparam int CW     = $clog2(TW);
  localparam int LW     = $clog2(TH*TW) + 1;
  localparam int PW0    = (STRIDE_0 > 1) ? $clog2(STRIDE_0) : 1;
  localparam int PW1    = (STRIDE_1 > 1) ? $clog2(STRIDE_1) : 1;
  localparam int RPH0   = (PADDING_0 >= W0-1) ? (PADDING_0-W0+1) % STRIDE_0 : 0;
  localparam int LAST_R = W0-1 + ((TH-W0)/STRIDE_0)*STRIDE_0;
  localparam int LAST_C = W1-1 + ((TW-W1)/STRIDE_1)*STRIDE_1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [RW-1:0]             r_q, r_d;
  logic [CW-1:0]             c_q, c_d;
  logic [LW-1:0]             lin_q, lin_d;
  logic [PW0-1:0]            rph_q, rph_d;
  logic [PW1-1:0]            cph_q, cph_d;
  logic                      o_valid_q, o_valid_d;
  logic                      o_last_q, o_last_d;
  logic [BLANK_PTS_SAFE-1:0] out_blank_q, out_blank_d;
  logic                      frame_done_q, frame_done_d;

  logic run, start_frame, drain_exit, shift;
  logic pad, slot_free, complete, last_pos;
  logic [BLANK_PTS_SAFE-1:0] blank_now;

  assign pad       = (int'(c_q) < PADDING_1) || (int'(c_q) >= PADDING_1 + IN_WIDTH)
                  || (int'(r_q) >= PADDING_0 + IN_HEIGHT);
  assign slot_free = !o_valid_q || bus.o_ready;
  assign complete  = (int'(r_q) >= W0-1) && (int'(c_q) >= W1-1) && (rph_q == '0) && (cph_q == '0);
  assign last_pos  = (int'(r_q) == LAST_R) && (int'(c_q) == LAST_C);

  // Points landing before the first shifted real pixel hold stale or never-written data.
  for (genvar p = 0; p < BLANK_PTS_SAFE; p++) begin : g_blank
    if (p < BLANK_PTS) begin : g_pt
      assign blank_now[p] = int'(lin_q) < BLANK_LIM + kofs(p);
    end else begin : g_zero
      assign blank_now[p] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (shift && int'(r_q) == TH-1 && int'(c_q) == TW-1) state_d = DRAIN;
      DRAIN:   if (drain_exit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run          = (state_q == RUN);
    busy         = (state_q != IDLE);
    start_frame  = (state_q == IDLE) && start;
    drain_exit   = (state_q == DRAIN) && slot_free;
    shift        = run && slot_free && (pad || bus.i_valid);
    frame_done_d = drain_exit;
  end

  assign bus.shift      = shift;
  assign bus.i_ready    = run && slot_free && !pad;
  assign bus.is_padding = run && pad;
  assign bus.o_valid    = o_valid_q;
  assign bus.o_last     = o_last_q;
  assign bus.out_blank  = out_blank_q;
  assign frame_done     = frame_done_q;

  // Phase counters are re-zeroed as the walk reaches the first window row/column.
  always_comb begin
    r_d   = r_q;
    c_d   = c_q;
    lin_d = lin_q;
    rph_d = rph_q;
    cph_d = cph_q;
    if (start_frame) begin
      r_d   = RW'(PADDING_0);
      c_d   = '0;
      lin_d = LW'(PADDING_0*TW);
      rph_d = PW0'(RPH0);
      cph_d = '0;
    end else if (shift) begin
      lin_d = lin_q + 1'b1;
      if (int'(c_q) == TW-1) begin
        c_d   = '0;
        r_d   = r_q + 1'b1;
        cph_d = '0;
        rph_d = (int'(r_q) + 1 == W0-1 || int'(rph_q) == STRIDE_0-1) ? '0 : rph_q + 1'b1;
      end else begin
        c_d   = c_q + 1'b1;
        cph_d = (int'(c_q) + 1 == W1-1 || int'(cph_q) == STRIDE_1-1) ? '0 : cph_q + 1'b1;
      end
    end
  end

  always_comb begin
    o_valid_d   = o_valid_q;
    o_last_d    = o_last_q;
    out_blank_d = out_blank_q;
    if (shift && complete) begin
      o_valid_d   = 1'b1;
      o_last_d    = last_pos;
      out_blank_d = blank_now;
    end else if (bus.o_ready) begin
      o_valid_d = 1'b0;
      o_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q          <= '0;
      c_q          <= '0;
      lin_q        <= '0;
      rph_q        <= '0;
      cph_q        <= '0;
      o_valid_q    <= 1'b0;
      o_last_q     <= 1'b0;
      out_blank_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      r_q          <= r_d;
      c_q          <= c_d;
      lin_q        <= lin_d;
      rph_q        <= rph_d;
      cph_q        <= cph_d;
      o_valid_q    <= o_valid_d;
      o_last_q     <= o_last_d;
      out_blank_q  <= out_blank_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Control stage for `line_buffer_datapath`. It walks one zero-padded frame position by position and drives the datapath's `shift`, `is_padding` and `out_blank` inputs. It accepts the input pixel stream through a valid/ready handshake and presents window-valid strobes to the downstream MAC array, with backpressure. Top padding rows are never shifted; the kernel points that would fall on them are blanked through `out_blank` instead.

## Interface
- `IN_HEIGHT`, 512, frame rows (real pixels)
- `IN_WIDTH`, 512, frame columns (real pixels)
- `KERNEL_0` / `KERNEL_1`, 3 / 3, kernel rows / columns
- `DILATION_0` / `DILATION_1`, 2 / 2
- `PADDING_0` / `PADDING_1`, 2 / 2, top+bottom / left+right padding
- `STRIDE_0` / `STRIDE_1`, 1 / 1, output decimation in rows / columns
- Derived (must match the datapath):
  - `TW = IN_WIDTH + 2*PADDING_1`, `TH = IN_HEIGHT + 2*PADDING_0`
  - `W0 = DILATION_0*(KERNEL_0-1)+1`, `W1` likewise
  - `BLANK_PTS` / `BLANK_PTS_SAFE` computed exactly as in the datapath
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `start`  in  1  begin one frame; ignored unless idle
- `busy`  out  1  frame in progress
- `frame_done`  out  1  one-cycle pulse after the last window is accepted
- `i_valid`  in  1  input pixel available
- `i_ready`  out  1  input pixel consumed this cycle
- `shift`  out  1  to datapath; window advances at this clock edge
- `is_padding`  out  1  to datapath; inject zero instead of `i_data`
- `out_blank`  out  `BLANK_PTS_SAFE`  to datapath; per-kernel-point zero mask, registered
- `o_valid`  out  1  datapath `o_data` holds a complete window
- `o_ready`  in  1  downstream accepts window
- `o_last`  out  1  qualifies the final window of the frame

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE → RUN on `start`. This loads position (r, c) = (`PADDING_0`, 0).
  - RUN → DRAIN when the shift at (`TH-1`, `TW-1`) occurs.
  - DRAIN → IDLE once `o_valid` is 0 or is accepted. `frame_done` pulses on that transition.
- **Padding position:** `pad = (c < PADDING_1) || (c >= PADDING_1+IN_WIDTH) || (r >= PADDING_0+IN_HEIGHT)`. Rows above `PADDING_0` are never visited.
- **Slot free:** `slot_free = !o_valid || o_ready`.
- **Shift condition:** `shift = RUN && slot_free && (pad || i_valid)`.
- **Input handshake:** `i_ready = RUN && slot_free && !pad`, so `i_ready & i_valid` implies `shift`. `is_padding = RUN && pad`.
- **Position advance on shift:** `c` wraps at `TW-1` to 0 and increments `r`.
- **Window completion:** a shift at (r, c) completes a window iff all three hold:
  - `r >= W0-1` and `c >= W1-1`
  - `(r-W0+1) % STRIDE_0 == 0`
  - `(c-W1+1) % STRIDE_1 == 0`
  - Stride phase is tracked with phase counters, not dividers.
- **Output valid:** `o_valid` sets on a completing shift. It clears on `o_ready` with no new completing shift. It holds while `!o_ready`, and no shift occurs in that case.
- **Last window:** `o_last` is registered with `o_valid`. It is 1 for the window whose newest point is (`TH-1`, `TW-1`), or the last stride-aligned position if that corner is not aligned.
- **Blank rule.** Kernel point p = i*`KERNEL_1`+j (i=0 is the top row, j=0 the left column):
  - It sits at (r-(`KERNEL_0`-1-i)*`DILATION_0`, c-(`KERNEL_1`-1-j)*`DILATION_1`).
  - `out_blank[p] = 1` iff that point's linear index row*`TW`+col is less than `PADDING_0*TW + PADDING_1`, i.e. top padding, or left padding of the first shifted row, whose FIFO contents are stale.
  - `out_blank` is registered on the completing shift and aligned with `o_valid`.
  - If `BLANK_PTS == 0`, `out_blank` is tied to 0.
- **Counter widths:** `$clog2(TH)` and `$clog2(TW)`. No overflow is possible within a frame.
- **`start` while busy:** ignored.
- **Reset mid-frame:** returns to IDLE immediately. The datapath contents are then garbage, and the blank rule covers them on the next frame.

## Timing
- **Reset values:** `busy`=0, `frame_done`=0, `o_valid`=0, `o_last`=0, `out_blank`=0, `i_ready`=0, `shift`=0, `is_padding`=0.
- **Combinational outputs:** `shift`, `i_ready` and `is_padding` are combinational from state and (r, c). `shift` and `i_ready` also depend on `i_valid`/`o_ready`. The paths `o_ready`→`shift` and `i_valid`→`shift` exist; downstream must not loop them.
- **Output latency:** `o_valid`/`out_blank`/`o_last` are asserted the cycle after the completing shift edge. This matches the datapath window register update.
- **Throughput:** one shift per cycle when `i_valid` and `o_ready` are held high.
- **Frame length:** each frame takes exactly `(TH-PADDING_0)*TW` shifts and consumes exactly `IN_HEIGHT*IN_WIDTH` inputs.

## Test plan
- **Nominal small frame.** Parameters 4x4, K=3, D=1, P=1, S=1; `i_valid`=`o_ready`=1; `start`.
  - Exactly 30 shifts, 16 `i_ready` beats, 16 windows.
  - `frame_done` pulses once, and `o_last` is set only on the 16th window.
- **Blank mask, same config.**
  - First window (newest (2,2)): `out_blank`=4'b1111.
  - Second window (2,3): 4'b0111.
  - Window at (3,2): 4'b0001.
  - All windows with r≥4: 4'b0000.
- **Backpressure.** Hold `o_ready`=0 for 5 cycles after the first `o_valid`.
  - `shift`=0 and `i_ready`=0 throughout; `o_valid` stays 1.
  - Data resumes with no loss after release.
- **Input starvation.** `i_valid`=0 on real-pixel positions.
  - No shift occurs; padding columns still shift without input.
  - Total `i_ready` beats remain 16.
- **Stride 2 (4x4, P=1).** Exactly 4 windows, at newest positions (2,2), (2,4), (4,2), (4,4).
- **Reset mid-frame.** Assert `rst_n` low at shift 12.
  - All outputs return to 0 and `busy`=0.
  - A following `start` yields a complete correct frame, with the first-window mask again 4'b1111.
